// File: rtl/stage3_finalize_if.sv
// Stage-3 bus bundle: stage-2 input handshake, key, output handshake and status.
interface stage3_finalize_if #(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [16:0]      in_data;
  logic [4:0]       key_bits;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             done;
  logic [LVL_W-1:0] level;

  modport master (
    output in_valid, in_data, key_bits, out_ready,
    input  in_ready, out_valid, out_data, done, level
  );

  modport slave (
    input  in_valid, in_data, key_bits, out_ready,
    output in_ready, out_valid, out_data, done, level
  );

endinterface

// File: rtl/stage3_finalize.sv
// Final crypto stage: key-dependent rotate + carry fold, FIFO buffering,
// valid/ready output and a per-frame done pulse.
module stage3_finalize #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  stage3_finalize_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [4:0]       key_l_q;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      out_data_q;
  logic             done_q;

  logic             accept_c;
  logic             pop_c;
  logic [4:0]       key_c;
  logic [31:0]      rot_c;
  logic [15:0]      result_c;
  logic [15:0]      head_c;

  // Handshakes, active key, transform and next FIFO head.
  always_comb begin
    accept_c = bus.in_valid & in_ready_q;
    pop_c    = out_valid_q & bus.out_ready;
    // First word of a frame uses the live key; the rest use the latched copy.
    key_c    = (in_cnt_q == '0) ? bus.key_bits : key_l_q;
    // Upper half of the doubled word shifted left is the rotate-left result.
    rot_c    = {bus.in_data[15:0], bus.in_data[15:0]} << key_c[3:0];
    if (key_c[4]) begin
      result_c = rot_c[31:16] ^ {16{bus.in_data[16]}};
    end else begin
      result_c = rot_c[31:16] + 16'(bus.in_data[16]);
    end
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(accept_c) - LVL_W'(pop_c);
    // A word written into the slot that becomes head is visible right after the edge.
    if (accept_c && (wr_ptr_q == rd_ptr_d)) begin
      head_c = result_c;
    end else begin
      head_c = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[wr_ptr_q] <= result_c;
    end
  end

  // FIFO pointers, occupancy and registered output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= (level_d != LVL_W'(DEPTH));
      out_valid_q <= (level_d != '0);
      if (level_d != '0) begin
        out_data_q <= head_c;
      end
    end
  end

  // Input frame FSM: counts accepted words and latches the key on word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      in_cnt_q <= '0;
      key_l_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            state_q  <= S_ACTIVE;
            in_cnt_q <= CNT_W'(1);
            key_l_q  <= bus.key_bits;
          end
        end
        S_ACTIVE: begin
          if (accept_c) begin
            if (in_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              state_q  <= S_IDLE;
              in_cnt_q <= '0;
            end else begin
              in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          in_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output frame counter and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop_c) begin
        if (out_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          out_cnt_q <= '0;
          done_q    <= 1'b1;
        end else begin
          out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_stage3_finalize.sv
// Scoreboard bench for stage3_finalize: driver pushes expected words,
// monitor pops them on every output transfer and tracks done timing.
module tb_stage3_finalize;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp      = 0;
  int n_err      = 0;
  int cyc        = 0;
  int done_total = 0;
  int last_acc   = 0;
  int first_acc  = 0;
  int d0         = 0;

  logic [15:0] exp_q [$];

  int          m_cnt    = 0;
  logic        done_exp = 1'b0;
  logic        done_nxt = 1'b0;
  logic        hold_v   = 1'b0;
  logic [15:0] hold_d   = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  stage3_finalize_if #(.DEPTH(DEPTH)) bus ();

  stage3_finalize #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every output transfer against the scoreboard and
  // predicts the done pulse from its own pop count.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        m_cnt    = 0;
        done_exp = 1'b0;
        hold_v   = 1'b0;
      end else begin
        chk("done_pulse", 32'(bus.done), 32'(done_exp));
        if (bus.done) done_total++;
        done_nxt = 1'b0;
        if (hold_v) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_data", 32'(bus.out_data), 32'(hold_d));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pop: got %0h, expected no word (t=%0t)", bus.out_data, $time);
          end else begin
            chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
          if (m_cnt == FRAME_LEN - 1) begin
            m_cnt    = 0;
            done_nxt = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_d   = bus.out_data;
        done_exp = done_nxt;
      end
    end
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one word (called 1 time unit after a rising edge); returns after the accept edge.
  task automatic send(input logic [16:0] d, input logic [4:0] k, input logic [15:0] e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.key_bits = k;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        last_acc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected accept of %0h", d);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_bits  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);

    // 1: rotate by 4, add fold, one-cycle latency
    bus.out_ready = 1'b1;
    send(17'h0_1234, 5'h04, 16'h2341);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'h2341);
    drain();
    do_reset();

    // 2: xor fold, then add wrap (each word starts its own frame)
    send(17'h1_1234, 5'h14, 16'hDCBE);
    drain();
    do_reset();
    send(17'h1_FFFF, 5'h04, 16'h0000);
    drain();
    do_reset();

    // 3: key latched on word 0, mid-frame key changes ignored, new key on next frame
    d0 = done_total;
    send(17'h0_0001, 5'h01, 16'h0002);
    for (int i = 1; i < 8; i++) send(17'h0_0001, 5'h08, 16'h0002);
    send(17'h0_0001, 5'h08, 16'h0100);
    drain();
    chk("t3_done_count", 32'(done_total - d0), 32'd1);
    do_reset();

    // 4: back-pressure fills the FIFO; 5th word waits for the first pop
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(17'(i), 5'h00, 16'(i));
      end
      begin
        repeat (8) @(negedge clk);
        chk("t4_level_full", 32'(bus.level), 32'd4);
        chk("t4_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t4_accepted", 32'(exp_q.size()), 32'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    do_reset();

    // 5: streaming 16 words at one word per cycle, two frames
    bus.out_ready = 1'b1;
    d0 = done_total;
    for (int i = 0; i < 16; i++) begin
      send(17'(i), 5'h00, 16'(i));
      if (i == 0) first_acc = last_acc;
      if (i == 8) chk("t5_level_steady", 32'(bus.level), 32'd1);
    end
    chk("t5_throughput", 32'(last_acc - first_acc), 32'd15);
    drain();
    chk("t5_done_count", 32'(done_total - d0), 32'd2);
    chk("t5_level_empty", 32'(bus.level), 32'd0);

    // 6: reset mid-frame with three words buffered and one word already popped
    send(17'h0_0011, 5'h00, 16'h0011);
    send(17'h0_0012, 5'h00, 16'h0012);
    bus.out_ready = 1'b0;
    send(17'h0_0013, 5'h00, 16'h0013);
    send(17'h0_0014, 5'h00, 16'h0014);
    chk("t6_level_before", 32'(bus.level), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_out_data", 32'(bus.out_data), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_level", 32'(bus.level), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    d0 = done_total;
    send(17'h0_0001, 5'h02, 16'h0004);
    for (int i = 1; i < 8; i++) send(17'h0_0001, 5'h03, 16'h0004);
    drain();
    chk("t6_done_count", 32'(done_total - d0), 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
